// File: rtl/gbe_tx_gmii.sv
// GMII transmit MAC stage: preamble/SFD insertion, short-frame padding, FCS append
// and inter-frame gap enforcement on a byte stream from the framer.
module gbe_tx_gmii #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514,
  parameter int PAD_EN    = 1
) (
  input  logic       mac_clk,
  input  logic       mac_rst,
  input  logic [7:0] mac_tx_data,
  input  logic       mac_tx_dvld,
  output logic       mac_tx_ack,
  input  logic       tx_enable,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_busy,
  output logic       tx_frame_sent,
  output logic       tx_frame_err
);

  localparam logic [15:0] MIN_W    = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_W    = 16'(MAX_FRAME);
  // IDLE itself supplies the last gap cycle, so IFG state lasts IFG_BYTES-1 cycles
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 2);
  localparam logic [15:0] IFG_FULL = 16'(IFG_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_DATA, ST_PAD, ST_FCS, ST_IFG
  } state_t;

  state_t      r_state;
  logic [2:0]  r_pre_cnt;
  logic [1:0]  r_fcs_idx;
  logic [15:0] r_byte_cnt;
  logic [15:0] r_ifg_cnt;
  logic [31:0] r_crc;
  logic        r_over;
  logic        r_err_pend;
  logic        r_ack;
  logic [7:0]  r_txd;
  logic        r_tx_en;
  logic        r_tx_er;
  logic        r_busy;
  logic        r_sent;
  logic        r_err;

  logic [15:0] w_cnt_inc;
  logic [31:0] w_crc_data;
  logic [31:0] w_crc_pad;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_byte;

  // Reflected CRC-32, one byte per clock, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 8; b++) begin
      c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_cnt_inc  = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
  assign w_crc_data = crc_byte(r_crc, mac_tx_data);
  assign w_crc_pad  = crc_byte(r_crc, 8'h00);
  assign w_fcs      = ~r_crc;
  assign w_fcs_byte = w_fcs[{r_fcs_idx, 3'b000} +: 8];

  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      r_state    <= ST_IDLE;
      r_pre_cnt  <= '0;
      r_fcs_idx  <= '0;
      r_byte_cnt <= '0;
      r_ifg_cnt  <= '0;
      r_crc      <= 32'hFFFFFFFF;
      r_over     <= 1'b0;
      r_err_pend <= 1'b0;
      r_ack      <= 1'b0;
      r_txd      <= 8'h00;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_busy     <= 1'b0;
      r_sent     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_sent <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          if (mac_tx_dvld && tx_enable) begin
            r_state   <= ST_PRE;
            r_busy    <= 1'b1;
            r_tx_en   <= 1'b1;
            r_txd     <= 8'h55;
            r_pre_cnt <= '0;
          end
        end
        ST_PRE: begin
          if (r_pre_cnt == 3'd6) begin
            r_txd      <= 8'hD5;
            r_ack      <= 1'b1;
            r_state    <= ST_DATA;
            r_byte_cnt <= '0;
            r_crc      <= 32'hFFFFFFFF;
            r_over     <= 1'b0;
          end else begin
            r_txd     <= 8'h55;
            r_pre_cnt <= r_pre_cnt + 3'd1;
          end
        end
        ST_DATA: begin
          if (mac_tx_dvld) begin
            r_txd      <= mac_tx_data;
            r_crc      <= w_crc_data;
            r_byte_cnt <= w_cnt_inc;
            if (r_byte_cnt >= MAX_W) begin
              r_over  <= 1'b1;
              r_tx_er <= 1'b1;
            end
          end else if (r_byte_cnt == 16'd0) begin
            // Empty frame: one error symbol, then a full gap after it
            r_txd      <= 8'h00;
            r_tx_er    <= 1'b1;
            r_err_pend <= 1'b1;
            r_ifg_cnt  <= IFG_FULL;
            r_state    <= ST_IFG;
          end else if (r_over) begin
            r_txd     <= 8'h00;
            r_tx_en   <= 1'b0;
            r_tx_er   <= 1'b0;
            r_err     <= 1'b1;
            r_ifg_cnt <= IFG_LAST;
            r_state   <= ST_IFG;
          end else if ((PAD_EN != 0) && (r_byte_cnt < MIN_W)) begin
            r_txd      <= 8'h00;
            r_crc      <= w_crc_pad;
            r_byte_cnt <= w_cnt_inc;
            r_state    <= ST_PAD;
          end else begin
            r_txd     <= w_fcs[7:0];
            r_fcs_idx <= 2'd1;
            r_state   <= ST_FCS;
          end
        end
        ST_PAD: begin
          if (r_byte_cnt < MIN_W) begin
            r_txd      <= 8'h00;
            r_crc      <= w_crc_pad;
            r_byte_cnt <= w_cnt_inc;
          end else begin
            r_txd     <= w_fcs[7:0];
            r_fcs_idx <= 2'd1;
            r_state   <= ST_FCS;
          end
        end
        ST_FCS: begin
          if (r_fcs_idx == 2'd0) begin
            r_txd     <= 8'h00;
            r_tx_en   <= 1'b0;
            r_sent    <= 1'b1;
            r_ifg_cnt <= IFG_LAST;
            r_state   <= ST_IFG;
          end else begin
            r_txd     <= w_fcs_byte;
            r_fcs_idx <= r_fcs_idx + 2'd1;
          end
        end
        ST_IFG: begin
          r_txd      <= 8'h00;
          r_tx_en    <= 1'b0;
          r_tx_er    <= 1'b0;
          r_err      <= r_err_pend;
          r_err_pend <= 1'b0;
          if (r_ifg_cnt == 16'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ifg_cnt <= r_ifg_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mac_tx_ack    = r_ack;
  assign gmii_txd      = r_txd;
  assign gmii_tx_en    = r_tx_en;
  assign gmii_tx_er    = r_tx_er;
  assign tx_busy       = r_busy;
  assign tx_frame_sent = r_sent;
  assign tx_frame_err  = r_err;

endmodule

// File: tb/tb_gbe_tx_gmii.sv
// Directed bench for gbe_tx_gmii: one padding and one non-padding instance share
// the stimulus; a monitor records bursts of the selected instance.
module tb_gbe_tx_gmii;

  logic       mac_clk = 1'b0;
  logic       mac_rst = 1'b1;
  logic [7:0] mac_tx_data = 8'h00;
  logic       mac_tx_dvld = 1'b0;
  logic       tx_enable = 1'b1;

  logic       p_ack, p_en, p_er, p_busy, p_sent, p_err;
  logic [7:0] p_txd;
  logic       n_ack, n_en, n_er, n_busy, n_sent, n_err;
  logic [7:0] n_txd;

  logic       sel_np = 1'b0;
  logic       m_ack, m_en, m_er, m_sent, m_err;
  logic [7:0] m_txd;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] fr [0:2047];
  logic [7:0] cap_q[$];
  logic       er_q[$];
  int         len_q[$];
  int         gap_q[$];
  int         ack_pos_q[$];
  int         cur_len, gap_cnt, en_cycles, ack_cnt, sent_cnt, err_cnt, both_cnt;
  bit         prev_en, seen_burst;

  initial forever #4 mac_clk = ~mac_clk;

  gbe_tx_gmii u_dut_pad (
    .mac_clk(mac_clk), .mac_rst(mac_rst), .mac_tx_data(mac_tx_data),
    .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(p_ack), .tx_enable(tx_enable),
    .gmii_txd(p_txd), .gmii_tx_en(p_en), .gmii_tx_er(p_er),
    .tx_busy(p_busy), .tx_frame_sent(p_sent), .tx_frame_err(p_err)
  );

  gbe_tx_gmii #(.PAD_EN(0)) u_dut_nopad (
    .mac_clk(mac_clk), .mac_rst(mac_rst), .mac_tx_data(mac_tx_data),
    .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(n_ack), .tx_enable(tx_enable),
    .gmii_txd(n_txd), .gmii_tx_en(n_en), .gmii_tx_er(n_er),
    .tx_busy(n_busy), .tx_frame_sent(n_sent), .tx_frame_err(n_err)
  );

  assign m_ack  = sel_np ? n_ack  : p_ack;
  assign m_en   = sel_np ? n_en   : p_en;
  assign m_er   = sel_np ? n_er   : p_er;
  assign m_txd  = sel_np ? n_txd  : p_txd;
  assign m_sent = sel_np ? n_sent : p_sent;
  assign m_err  = sel_np ? n_err  : p_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Burst recorder, sampled on the falling edge
  initial forever begin
    @(negedge mac_clk);
    if (m_en) begin
      cap_q.push_back(m_txd);
      er_q.push_back(m_er);
      if (!prev_en && seen_burst) gap_q.push_back(gap_cnt);
      cur_len++;
      seen_burst = 1'b1;
      gap_cnt = 0;
      en_cycles++;
    end else begin
      if (prev_en) len_q.push_back(cur_len);
      cur_len = 0;
      gap_cnt++;
    end
    if (m_ack) begin
      ack_cnt++;
      ack_pos_q.push_back(cur_len - 1);
    end
    if (m_sent) sent_cnt++;
    if (m_err) err_cnt++;
    if (m_sent && m_err) both_cnt++;
    prev_en = m_en;
  end

  task automatic clr_mon();
    cap_q.delete(); er_q.delete(); len_q.delete(); gap_q.delete(); ack_pos_q.delete();
    cur_len = 0; gap_cnt = 0; en_cycles = 0; ack_cnt = 0;
    sent_cnt = 0; err_cnt = 0; prev_en = 1'b0; seen_burst = 1'b0;
  endtask

  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Framer model: hold byte 0 until ack, then one byte per clock, then drop dvld
  task automatic drive_frame(input int n);
    bit got;
    got = 1'b0;
    mac_tx_dvld = 1'b1;
    mac_tx_data = fr[0];
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge mac_clk);
      if (m_ack) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (n == 0) mac_tx_dvld = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge mac_clk); #1;
      if (i < n) mac_tx_data = fr[i];
      else begin
        mac_tx_dvld = 1'b0;
        mac_tx_data = 8'h00;
      end
    end
    $display("frame n=%0d driven at %0t", n, $time);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge mac_clk);
    while ((p_busy || n_busy) && c < 3000) begin
      @(negedge mac_clk);
      c++;
    end
    chk("idle", 32'(p_busy | n_busy), 32'd0);
    repeat (2) @(posedge mac_clk);
    #1;
  endtask

  function automatic logic [31:0] fcs_at(input int base);
    return {cap_q[base+3], cap_q[base+2], cap_q[base+1], cap_q[base]};
  endfunction

  initial begin
    int bad;
    int er_sum;
    string s;
    logic [31:0] exp_fcs;

    repeat (3) @(posedge mac_clk);
    @(negedge mac_clk);
    chk("reset_pad", {18'h0, p_ack, p_txd, p_en, p_er, p_busy, p_sent, p_err}, 32'd0);
    chk("reset_nopad", {18'h0, n_ack, n_txd, n_en, n_er, n_busy, n_sent, n_err}, 32'd0);
    @(posedge mac_clk); #1;
    mac_rst = 1'b0;
    repeat (2) @(posedge mac_clk); #1;

    // 1: no padding, "123456789"
    sel_np = 1'b1;
    clr_mon();
    s = "123456789";
    for (int i = 0; i < 9; i++) fr[i] = s[i];
    drive_frame(9);
    wait_idle();
    chk("t1_len", 32'(len_q[0]), 32'd21);
    bad = 0;
    for (int i = 0; i < 7; i++) if (cap_q[i] != 8'h55) bad++;
    chk("t1_preamble", 32'(bad), 32'd0);
    chk("t1_sfd", 32'(cap_q[7]), 32'hD5);
    bad = 0;
    for (int i = 0; i < 9; i++) if (cap_q[8+i] != fr[i]) bad++;
    chk("t1_data", 32'(bad), 32'd0);
    chk("t1_fcs", fcs_at(17), 32'hCBF43926);
    chk("t1_acks", 32'(ack_cnt), 32'd1);
    chk("t1_ack_pos", 32'(ack_pos_q[0]), 32'd7);
    chk("t1_sent", 32'(sent_cnt), 32'd1);

    // 2: 42-byte frame padded to 60
    sel_np = 1'b0;
    clr_mon();
    for (int i = 0; i < 42; i++) fr[i] = 8'(i * 7 + 3);
    for (int i = 42; i < 60; i++) fr[i] = 8'h00;
    exp_fcs = crc_ref(60);
    drive_frame(42);
    wait_idle();
    chk("t2_len", 32'(len_q[0]), 32'd72);
    bad = 0;
    for (int i = 0; i < 42; i++) if (cap_q[8+i] != fr[i]) bad++;
    chk("t2_data", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 50; i < 68; i++) if (cap_q[i] != 8'h00) bad++;
    chk("t2_pad", 32'(bad), 32'd0);
    chk("t2_fcs", fcs_at(68), exp_fcs);
    chk("t2_sent_err", 32'({sent_cnt[7:0], err_cnt[7:0]}), 32'h0100);

    // 3: two back-to-back 100-byte frames
    clr_mon();
    for (int i = 0; i < 100; i++) fr[i] = 8'(i * 13 + 1);
    exp_fcs = crc_ref(100);
    drive_frame(100);
    @(posedge mac_clk); #1;
    drive_frame(100);
    wait_idle();
    chk("t3_bursts", 32'(len_q.size()), 32'd2);
    chk("t3_len0", 32'(len_q[0]), 32'd112);
    chk("t3_len1", 32'(len_q[1]), 32'd112);
    chk("t3_gap", 32'(gap_q[0]), 32'd12);
    chk("t3_ack2_pos", 32'(ack_pos_q[1]), 32'd7);
    chk("t3_fcs2", fcs_at(220), exp_fcs);
    chk("t3_sent", 32'(sent_cnt), 32'd2);

    // Empty frame: dvld drops in the ack cycle
    clr_mon();
    drive_frame(0);
    wait_idle();
    chk("t0_len", 32'(len_q[0]), 32'd9);
    chk("t0_er_last", 32'(er_q[8]), 32'd1);
    er_sum = 0;
    foreach (er_q[i]) er_sum += int'(er_q[i]);
    chk("t0_er_sum", 32'(er_sum), 32'd1);
    chk("t0_sent_err", 32'({sent_cnt[7:0], err_cnt[7:0]}), 32'h0001);

    // 4: oversize 1515-byte frame followed by a short frame
    clr_mon();
    for (int i = 0; i < 1515; i++) fr[i] = 8'(i);
    drive_frame(1515);
    @(posedge mac_clk); #1;
    drive_frame(9);
    wait_idle();
    chk("t4_len", 32'(len_q[0]), 32'd1523);
    chk("t4_er_1514", 32'(er_q[1522]), 32'd1);
    chk("t4_er_1513", 32'(er_q[1521]), 32'd0);
    er_sum = 0;
    foreach (er_q[i]) er_sum += int'(er_q[i]);
    chk("t4_er_sum", 32'(er_sum), 32'd1);
    chk("t4_gap", 32'(gap_q[0]), 32'd12);
    chk("t4_sent_err", 32'({sent_cnt[7:0], err_cnt[7:0]}), 32'h0101);

    // 5: reset at data byte 30 of a 200-byte frame
    clr_mon();
    for (int i = 0; i < 200; i++) fr[i] = 8'(255 - i);
    mac_tx_dvld = 1'b1;
    mac_tx_data = fr[0];
    bad = 1;
    for (int c = 0; c < 400 && bad != 0; c++) begin
      @(negedge mac_clk);
      if (m_ack) bad = 0;
    end
    chk("t5_ack", 32'(bad), 32'd0);
    for (int i = 1; i <= 30; i++) begin
      @(posedge mac_clk); #1;
      mac_tx_data = fr[i];
    end
    mac_rst = 1'b1;
    @(posedge mac_clk); #1;
    mac_rst = 1'b0;
    mac_tx_data = fr[0];
    @(negedge mac_clk);
    chk("t5_en_after_rst", 32'(m_en), 32'd0);
    @(negedge mac_clk);
    chk("t5_t0", {23'h0, m_en, m_txd}, 32'h155);
    chk("t5_no_pulse", 32'(sent_cnt + err_cnt), 32'd0);
    drive_frame(40);
    wait_idle();
    chk("t5_len", 32'(len_q[len_q.size()-1]), 32'd72);
    chk("t5_sent_err", 32'({sent_cnt[7:0], err_cnt[7:0]}), 32'h0100);

    // 6: start held off by tx_enable
    clr_mon();
    tx_enable = 1'b0;
    mac_tx_dvld = 1'b1;
    mac_tx_data = fr[0];
    repeat (50) @(posedge mac_clk);
    #1;
    chk("t6_disabled", 32'(ack_cnt + en_cycles), 32'd0);
    tx_enable = 1'b1;
    @(negedge mac_clk);
    chk("t6_s_cycle", 32'(m_en), 32'd0);
    @(negedge mac_clk);
    chk("t6_t0", {23'h0, m_en, m_txd}, 32'h155);
    tx_enable = 1'b0;
    drive_frame(20);
    wait_idle();
    tx_enable = 1'b1;
    chk("t6_len", 32'(len_q[0]), 32'd72);
    chk("t6_sent", 32'(sent_cnt), 32'd1);

    chk("never_both", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
